pad_cfg_ctrl: RTL and testbench



---
 rtl/pad_cfg_pkg.sv | 81 ++++++++
 rtl/pad_cfg_decode.sv | 44 ++++
 rtl/pad_cfg_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pad_cfg_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_cfg_pkg.sv
// Shared definitions for the pad configuration controller.
// Holds the per-pad config word layout, the per-pad control bundle,
// the fixed control-value presets for safe/input/output modes and the
// top-level state encoding. No ports: this is a package.
package pad_cfg_pkg;

  localparam int NUM_PADS_DEF = 48;
  localparam int ADDR_W       = 6;

  // Bit positions of each field inside the 8-bit config word.
  localparam int CFG_DIR     = 0;
  localparam int CFG_DRV_LSB = 1;
  localparam int CFG_PU      = 4;
  localparam int CFG_PD      = 5;
  localparam int CFG_SLEW    = 6;
  localparam int CFG_RSVD    = 7;

  // Config word as stored per pad; packing order matches the bit positions above.
  typedef struct packed {
    logic       rsvd;
    logic       slew;
    logic       pd_en;
    logic       pu_en;
    logic [2:0] drv;
    logic       dir;
  } pad_cfg_t;

  // The eleven control bits that leave the block for one pad.
  typedef struct packed {
    logic [2:0] drv;
    logic       enabq;
    logic       enq;
    logic       pd;
    logic       ppen;
    logic       prg_slew;
    logic       puq;
    logic       pwrup_pull_en;
    logic       pwrupzhl;
  } pad_ctrl_t;

  // Driver off, pulls off, no power-up overrides.
  localparam pad_ctrl_t CTRL_SAFE = '{drv: 3'b000, enabq: 1'b0, enq: 1'b1, pd: 1'b0,
                                      ppen: 1'b0, prg_slew: 1'b0, puq: 1'b1,
                                      pwrup_pull_en: 1'b0, pwrupzhl: 1'b0};

  // Receiver-only setting; drive, slew and pulls are overlaid from the cfg word.
  localparam pad_ctrl_t CTRL_IN   = '{drv: 3'b000, enabq: 1'b0, enq: 1'b1, pd: 1'b0,
                                      ppen: 1'b0, prg_slew: 1'b0, puq: 1'b1,
                                      pwrup_pull_en: 1'b0, pwrupzhl: 1'b0};

  // Driver-enabled setting; drive, slew and pulls are overlaid from the cfg word.
  localparam pad_ctrl_t CTRL_OUT  = '{drv: 3'b000, enabq: 1'b1, enq: 1'b0, pd: 1'b0,
                                      ppen: 1'b1, prg_slew: 1'b0, puq: 1'b1,
                                      pwrup_pull_en: 1'b0, pwrupzhl: 1'b0};

  typedef enum logic {
    ST_HOLD,
    ST_ACTIVE
  } state_t;

  // Builds a config struct from a raw bus word using the field positions.
  function automatic pad_cfg_t cfg_unpack(input logic [7:0] w);
    pad_cfg_t c;
    c.dir   = w[CFG_DIR];
    c.drv   = w[CFG_DRV_LSB +: 3];
    c.pu_en = w[CFG_PU];
    c.pd_en = w[CFG_PD];
    c.slew  = w[CFG_SLEW];
    c.rsvd  = w[CFG_RSVD];
    return c;
  endfunction

  // Reset-time config: everything cleared except the direction bit.
  function automatic pad_cfg_t cfg_default(input logic dir);
    logic [7:0] w;
    w          = '0;
    w[CFG_DIR] = dir;
    return cfg_unpack(w);
  endfunction

endpackage

// File: rtl/pad_cfg_decode.sv
// Per-pad control decoder.
// Maps one pad's config word plus the safe and hold flags onto the
// eleven pad control bits. Purely combinational; the top registers it.
// Ports:
//   cfg  - stored config word for this pad
//   safe - pad is in a direction-change turnaround
//   hold - block is in the power-up hold phase
//   ctrl - resulting control bundle for this pad
module pad_cfg_decode
  import pad_cfg_pkg::*;
(
  input  pad_cfg_t  cfg,
  input  logic      safe,
  input  logic      hold,
  output pad_ctrl_t ctrl
);

  logic unused_rsvd;
  assign unused_rsvd = cfg.rsvd;

  // Hold dominates everything and also raises the power-up overrides.
  // Turnaround forces the safe preset. Otherwise the direction picks the
  // base preset and drive, slew and pulls come from the config word.
  // Asking for both pulls at once would fight, so both are switched off.
  always_comb begin
    ctrl = CTRL_SAFE;
    if (hold) begin
      ctrl.pwrupzhl      = 1'b1;
      ctrl.pwrup_pull_en = 1'b1;
    end else if (!safe) begin
      ctrl          = cfg.dir ? CTRL_OUT : CTRL_IN;
      ctrl.drv      = cfg.drv;
      ctrl.prg_slew = cfg.slew;
      if (cfg.pu_en && cfg.pd_en) begin
        ctrl.puq = 1'b1;
        ctrl.pd  = 1'b0;
      end else begin
        ctrl.puq = ~cfg.pu_en;
        ctrl.pd  = cfg.pd_en;
      end
    end
  end

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Runtime configuration and sequencing controller for the pad ring.
// Keeps a config word per pad, holds all pads safe for a fixed time after
// reset, and routes every direction change through a timed driver-off phase.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   wr_valid/wr_ready     - config write handshake; wr_addr selects the pad,
//                           wr_data is the config word
//   wr_err                - one-cycle pulse when an accepted write was dropped
//   lock_i                - sticky write lock request
//   rd_addr/rd_data       - registered readback of the stored config word
//   active                - power-up hold finished
//   drv0..pwrupzhl        - registered per-pad control vectors, bit i = pad i
module pad_cfg_ctrl
  import pad_cfg_pkg::*;
#(
  parameter int                  NUM_PADS     = NUM_PADS_DEF,
  parameter int                  PWRUP_CYCLES = 64,
  parameter int                  TURN_CYCLES  = 4,
  parameter logic [NUM_PADS-1:0] DEFAULT_DIR  = 48'hFFFF_FFFF_F0C0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [7:0]          wr_data,
  output logic                wr_err,
  input  logic                lock_i,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [7:0]          rd_data,
  output logic                active,
  output logic [NUM_PADS-1:0] drv0,
  output logic [NUM_PADS-1:0] drv1,
  output logic [NUM_PADS-1:0] drv2,
  output logic [NUM_PADS-1:0] enabq,
  output logic [NUM_PADS-1:0] enq,
  output logic [NUM_PADS-1:0] pd,
  output logic [NUM_PADS-1:0] ppen,
  output logic [NUM_PADS-1:0] prg_slew,
  output logic [NUM_PADS-1:0] puq,
  output logic [NUM_PADS-1:0] pwrup_pull_en,
  output logic [NUM_PADS-1:0] pwrupzhl
);

  localparam int PW_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam int TN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [PW_W-1:0]   PW_LAST  = PW_W'(PWRUP_CYCLES - 1);
  localparam logic [TN_W-1:0]   TN_LAST  = TN_W'(TURN_CYCLES - 1);
  localparam logic [ADDR_W:0]   PADS_LIM = (ADDR_W + 1)'(NUM_PADS);

  state_t              state_q, state_d;
  logic [PW_W-1:0]     pwr_cnt_q, pwr_cnt_d;
  logic                lock_q, lock_d;
  logic                turn_busy_q, turn_busy_d;
  logic [TN_W-1:0]     turn_cnt_q, turn_cnt_d;
  logic [ADDR_W-1:0]   turn_idx_q, turn_idx_d;
  logic                wr_err_d;
  pad_cfg_t            cfg_q [NUM_PADS];
  pad_cfg_t            cfg_d [NUM_PADS];
  pad_cfg_t            wr_cfg;
  logic                accept, drop;
  logic [7:0]          rd_word;
  logic [NUM_PADS-1:0] safe_d;
  logic                hold_d;
  logic                active_d, ready_d;
  pad_ctrl_t           ctrl_d [NUM_PADS];

  // Next-state logic. HOLD just counts out the power-up time. In ACTIVE the
  // shared turnaround timer runs down, and an accepted write either gets
  // dropped (bad address or lock) or lands in the config file; a write that
  // flips direction also arms the turnaround for that pad. Only one
  // turnaround can be pending because wr_ready is low while it runs.
  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    lock_d      = lock_q | lock_i;
    turn_busy_d = turn_busy_q;
    turn_cnt_d  = turn_cnt_q;
    turn_idx_d  = turn_idx_q;
    wr_err_d    = 1'b0;
    cfg_d       = cfg_q;
    wr_cfg      = cfg_unpack(wr_data);
    accept      = wr_valid & wr_ready;
    drop        = ({1'b0, wr_addr} >= PADS_LIM) | lock_q | lock_i;
    case (state_q)
      ST_HOLD: begin
        if (pwr_cnt_q == PW_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PW_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (turn_busy_q) begin
          if (turn_cnt_q == TN_LAST) begin
            turn_busy_d = 1'b0;
          end else begin
            turn_cnt_d = turn_cnt_q + TN_W'(1);
          end
        end
        if (accept) begin
          if (drop) begin
            wr_err_d = 1'b1;
          end else begin
            for (int i = 0; i < NUM_PADS; i++) begin
              if (wr_addr == ADDR_W'(i)) begin
                if (wr_cfg.dir != cfg_q[i].dir) begin
                  turn_busy_d = 1'b1;
                  turn_cnt_d  = '0;
                  turn_idx_d  = wr_addr;
                end
                cfg_d[i] = wr_cfg;
              end
            end
          end
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // Look-ahead flags for the pin registers, so pins follow the config that
  // becomes current on the same edge rather than lagging by one cycle.
  always_comb begin
    hold_d   = (state_d == ST_HOLD);
    active_d = (state_d == ST_ACTIVE);
    ready_d  = active_d & ~turn_busy_d;
    for (int i = 0; i < NUM_PADS; i++) begin
      safe_d[i] = turn_busy_d && (turn_idx_d == ADDR_W'(i));
    end
  end

  // Readback mux; addresses past the last pad read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_word = cfg_q[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    pad_cfg_decode u_decode (
      .cfg  (cfg_d[g]),
      .safe (safe_d[g]),
      .hold (hold_d),
      .ctrl (ctrl_d[g])
    );
  end

  // Control state, config file and status outputs. Reset drops everything
  // back into HOLD with the default directions and clears the lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_HOLD;
      pwr_cnt_q   <= '0;
      lock_q      <= 1'b0;
      turn_busy_q <= 1'b0;
      turn_cnt_q  <= '0;
      turn_idx_q  <= '0;
      wr_err      <= 1'b0;
      wr_ready    <= 1'b0;
      active      <= 1'b0;
      rd_data     <= '0;
      for (int i = 0; i < NUM_PADS; i++) begin
        cfg_q[i] <= cfg_default(DEFAULT_DIR[i]);
      end
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      lock_q      <= lock_d;
      turn_busy_q <= turn_busy_d;
      turn_cnt_q  <= turn_cnt_d;
      turn_idx_q  <= turn_idx_d;
      wr_err      <= wr_err_d;
      wr_ready    <= ready_d;
      active      <= active_d;
      rd_data     <= rd_word;
      cfg_q       <= cfg_d;
    end
  end

  // Pin registers. Reset loads the hold pattern directly; otherwise each
  // bit takes its decoder result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drv0          <= '0;
      drv1          <= '0;
      drv2          <= '0;
      enabq         <= '0;
      enq           <= '1;
      pd            <= '0;
      ppen          <= '0;
      prg_slew      <= '0;
      puq           <= '1;
      pwrup_pull_en <= '1;
      pwrupzhl      <= '1;
    end else begin
      for (int i = 0; i < NUM_PADS; i++) begin
        drv0[i]          <= ctrl_d[i].drv[0];
        drv1[i]          <= ctrl_d[i].drv[1];
        drv2[i]          <= ctrl_d[i].drv[2];
        enabq[i]         <= ctrl_d[i].enabq;
        enq[i]           <= ctrl_d[i].enq;
        pd[i]            <= ctrl_d[i].pd;
        ppen[i]          <= ctrl_d[i].ppen;
        prg_slew[i]      <= ctrl_d[i].prg_slew;
        puq[i]           <= ctrl_d[i].puq;
        pwrup_pull_en[i] <= ctrl_d[i].pwrup_pull_en;
        pwrupzhl[i]      <= ctrl_d[i].pwrupzhl;
      end
    end
  end

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed testbench for pad_cfg_ctrl: power-up hold, direct writes,
// direction turnaround, pull mapping, write drops, lock and reset aborts.
module tb_pad_cfg_ctrl;

  localparam logic [47:0] DEF_DIR  = 48'hFFFF_FFFF_F0C0;
  localparam logic [47:0] ALL_ONES = 48'hFFFF_FFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_err;
  logic        lock_i;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        active;
  logic [47:0] drv0, drv1, drv2, enabq, enq, pd, ppen, prg_slew, puq;
  logic [47:0] pwrup_pull_en, pwrupzhl;

  int tests_run    = 0;
  int tests_failed = 0;

  // 10 ns clock.
  always #5 clk_i = ~clk_i;

  pad_cfg_ctrl #(
    .NUM_PADS     (48),
    .PWRUP_CYCLES (64),
    .TURN_CYCLES  (4),
    .DEFAULT_DIR  (DEF_DIR)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_err        (wr_err),
    .lock_i        (lock_i),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .active        (active),
    .drv0          (drv0),
    .drv1          (drv1),
    .drv2          (drv2),
    .enabq         (enabq),
    .enq           (enq),
    .pd            (pd),
    .ppen          (ppen),
    .prg_slew      (prg_slew),
    .puq           (puq),
    .pwrup_pull_en (pwrup_pull_en),
    .pwrupzhl      (pwrupzhl)
  );

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drives the write-request inputs.
  task automatic applyStimulus(input logic valid, input logic [5:0] addr, input logic [7:0] data);
    wr_valid = valid;
    wr_addr  = addr;
    wr_data  = data;
  endtask

  // Advances one clock and settles just after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a write, waits (bounded) for wr_ready, and returns one cycle
  // after the accepting edge with wr_valid dropped.
  task automatic writeCfg(input logic [5:0] addr, input logic [7:0] data);
    int waited;
    applyStimulus(1'b1, addr, data);
    waited = 0;
    while (!wr_ready && waited < 50) begin
      step();
      waited++;
    end
    checkOutput("wr_ready_wait", 48'(wr_ready), 48'd1);
    step();
    applyStimulus(1'b0, addr, data);
  endtask

  task automatic readBack(input logic [5:0] addr, output logic [7:0] data);
    rd_addr = addr;
    step();
    data = rd_data;
  endtask

  task automatic resetDut();
    rst_i  = 1'b1;
    lock_i = 1'b0;
    applyStimulus(1'b0, 6'd0, 8'h00);
    step();
    step();
    rst_i = 1'b0;
  endtask

  // Counts cycles until active rises (bounded) and how many of those hold
  // cycles showed anything other than the power-up pattern.
  task automatic waitActive(output int cycles, output int bad);
    cycles = 0;
    bad    = 0;
    while (!active && cycles < 200) begin
      if (pwrupzhl !== ALL_ONES || pwrup_pull_en !== ALL_ONES ||
          wr_ready !== 1'b0 || enabq !== 48'h0)
        bad++;
      cycles++;
      step();
    end
  endtask

  initial begin
    int          n;
    int          bad;
    logic [7:0]  rb;
    logic [47:0] exp_enabq;
    logic [47:0] exp_drv0;

    rst_i   = 1'b1;
    lock_i  = 1'b0;
    rd_addr = 6'd0;
    applyStimulus(1'b0, 6'd0, 8'h00);

    // Reset state.
    resetDut();
    checkOutput("rst_pwrupzhl", pwrupzhl, ALL_ONES);
    checkOutput("rst_pull_en", pwrup_pull_en, ALL_ONES);
    checkOutput("rst_enq", enq, ALL_ONES);
    checkOutput("rst_enabq", enabq, 48'h0);
    checkOutput("rst_flags", {45'b0, active, wr_ready, wr_err}, 48'h0);

    // Power-up hold length and entry into ACTIVE.
    waitActive(n, bad);
    checkOutput("hold_len", 48'(n), 48'd64);
    checkOutput("hold_pins", 48'(bad), 48'd0);
    checkOutput("act_ready", {46'b0, active, wr_ready}, 48'b11);
    checkOutput("act_pwrupzhl", pwrupzhl, 48'h0);
    checkOutput("act_pull_en", pwrup_pull_en, 48'h0);
    checkOutput("act_enabq", enabq, DEF_DIR);
    checkOutput("act_enq", enq, ~DEF_DIR);
    checkOutput("act_ppen", ppen, DEF_DIR);
    checkOutput("act_puq", puq, ALL_ONES);
    checkOutput("act_drv", drv0 | drv1 | drv2 | pd | prg_slew, 48'h0);
    readBack(6'd8, rb);
    checkOutput("rd_pad8", 48'(rb), 48'h00);
    readBack(6'd40, rb);
    checkOutput("rd_pad40", 48'(rb), 48'h01);

    // Same-direction write goes straight to the pins.
    exp_enabq = DEF_DIR;
    exp_drv0  = 48'h0000_0010_0000;
    rd_addr   = 6'd20;
    writeCfg(6'd20, 8'h0F);
    checkOutput("w20_drv0", drv0, exp_drv0);
    checkOutput("w20_drv12", {46'b0, drv1[20], drv2[20]}, 48'b11);
    checkOutput("w20_enabq", enabq, exp_enabq);
    checkOutput("w20_err", 48'(wr_err), 48'd0);
    step();
    checkOutput("rd_pad20", 48'(rd_data), 48'h0F);

    // Input-to-output write on pad 0, with a second write held off meanwhile.
    writeCfg(6'd0, 8'h01);
    applyStimulus(1'b1, 6'd21, 8'h03);
    rd_addr = 6'd0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("turn_c%0d", k), {44'b0, enabq[0], enq[0], ppen[0], wr_ready}, 48'b0100);
      checkOutput($sformatf("turn_held%0d", k), drv0, exp_drv0);
      if (k == 1) checkOutput("turn_rd", 48'(rd_data), 48'h01);
      step();
    end
    exp_enabq = DEF_DIR | 48'h1;
    checkOutput("turn_done", {44'b0, enabq[0], enq[0], ppen[0], wr_ready}, 48'b1011);
    step();
    applyStimulus(1'b0, 6'd21, 8'h03);
    exp_drv0 = 48'h0000_0030_0000;
    checkOutput("w21_drv0", drv0, exp_drv0);
    checkOutput("w21_enabq", enabq, exp_enabq);

    // Pull mapping on pad 3 (input).
    writeCfg(6'd3, 8'h30);
    checkOutput("pull_both", {46'b0, puq[3], pd[3]}, 48'b10);
    readBack(6'd3, rb);
    checkOutput("rd_pad3_30", 48'(rb), 48'h30);
    writeCfg(6'd3, 8'h10);
    checkOutput("pull_up", {46'b0, puq[3], pd[3]}, 48'b00);
    writeCfg(6'd3, 8'h60);
    checkOutput("pull_dn_slew", {45'b0, puq[3], pd[3], prg_slew[3]}, 48'b111);
    checkOutput("pd_vec", pd, 48'h8);
    checkOutput("slew_vec", prg_slew, 48'h8);
    readBack(6'd3, rb);
    checkOutput("rd_pad3_60", 48'(rb), 48'h60);

    // Address range: 50 and 48 dropped, 47 accepted.
    writeCfg(6'd50, 8'hFF);
    checkOutput("a50_err", 48'(wr_err), 48'd1);
    checkOutput("a50_enabq", enabq, exp_enabq);
    checkOutput("a50_drv0", drv0, exp_drv0);
    step();
    checkOutput("err_pulse", 48'(wr_err), 48'd0);
    writeCfg(6'd48, 8'hFF);
    checkOutput("a48_err", 48'(wr_err), 48'd1);
    writeCfg(6'd47, 8'h03);
    exp_drv0 = 48'h8000_0030_0000;
    checkOutput("a47_err", 48'(wr_err), 48'd0);
    checkOutput("a47_drv0", drv0, exp_drv0);
    readBack(6'd63, rb);
    checkOutput("rd_pad63", 48'(rb), 48'h00);

    // Lock raised in the same cycle as a write, then sticky.
    lock_i = 1'b1;
    writeCfg(6'd17, 8'h00);
    lock_i = 1'b0;
    checkOutput("lock_same_err", 48'(wr_err), 48'd1);
    checkOutput("lock_same_enabq", enabq, exp_enabq);
    writeCfg(6'd16, 8'h00);
    checkOutput("lock_err", 48'(wr_err), 48'd1);
    checkOutput("lock_enabq", enabq, exp_enabq);
    readBack(6'd16, rb);
    checkOutput("lock_rd16", 48'(rb), 48'h01);

    // Reset partway through HOLD restarts the full hold time.
    resetDut();
    repeat (30) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    waitActive(n, bad);
    checkOutput("rehold_len", 48'(n), 48'd64);
    checkOutput("rehold_pins", 48'(bad), 48'd0);

    // Lock was cleared: a direction change on pad 5 is accepted, then reset mid-turnaround.
    writeCfg(6'd5, 8'h01);
    checkOutput("p5_err", 48'(wr_err), 48'd0);
    checkOutput("p5_turn", {46'b0, enabq[5], wr_ready}, 48'b00);
    step();
    rst_i = 1'b1;
    step();
    checkOutput("rst_turn_pins", pwrupzhl, ALL_ONES);
    checkOutput("rst_turn_flags", {46'b0, active, wr_ready}, 48'b00);
    rst_i = 1'b0;
    waitActive(n, bad);
    checkOutput("rst_turn_len", 48'(n), 48'd64);
    checkOutput("def_enabq", enabq, DEF_DIR);
    checkOutput("def_drv0", drv0, 48'h0);
    checkOutput("def_slew_pd", prg_slew | pd, 48'h0);
    readBack(6'd5, rb);
    checkOutput("def_rd5", 48'(rb), 48'h00);
    readBack(6'd20, rb);
    checkOutput("def_rd20", 48'(rb), 48'h01);
    readBack(6'd3, rb);
    checkOutput("def_rd3", 48'(rb), 48'h00);
    writeCfg(6'd16, 8'h03);
    checkOutput("unlock_err", 48'(wr_err), 48'd0);
    checkOutput("unlock_drv0", drv0, 48'h0000_0001_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
